// File: rtl/bit_receiver.sv
// bit_receiver: serial receive end of the character link.
// Frame: start 0, 7 data bits LSB first, parity, stop 1; line idles at 1.
// The line is oversampled with clk; each bit is sampled once near its middle.
// A received character is held behind a DataReady/ReadAck handshake.
module bit_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       RxBit,
    input  logic       ReadAck,
    output logic [6:0] Char,
    output logic       RxParity,
    output logic       DataReady,
    output logic       ParityError,
    output logic       FrameError,
    output logic       Overrun,
    output logic       Busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    logic          rx_m, rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [6:0]    data;
    logic          par_s;
    logic          stop_s;
    logic          deliver;

    // Two-flop synchronizer; resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (Reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RxBit;
            rx_s <= rx_m;
        end
    end

    // Frame FSM: locate the start bit, then sample every bit at its middle.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            data    <= '0;
            par_s   <= 1'b0;
            stop_s  <= 1'b0;
            deliver <= 1'b0;
        end else begin
            deliver <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= S_START;
                end
                S_START: begin
                    // Half a bit in: confirm the line is still low, else it was a glitch.
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt  <= '0;
                        // Shift in from the top so the first bit lands in data[0].
                        data <= {rx_s, data[6:1]};
                        if (idx == 3'd6) state <= S_PARITY;
                        else             idx   <= idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        par_s <= rx_s;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        stop_s  <= rx_s;
                        deliver <= 1'b1;
                        // A low stop bit may be a break; wait for the line to recover.
                        state   <= rx_s ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output holding registers and the consumer handshake.
    always_ff @(posedge clk) begin
        if (Reset) begin
            Char        <= '0;
            RxParity    <= 1'b0;
            DataReady   <= 1'b0;
            ParityError <= 1'b0;
            FrameError  <= 1'b0;
            Overrun     <= 1'b0;
        end else if (deliver) begin
            Char        <= data;
            RxParity    <= par_s;
            ParityError <= ((^data) ^ par_s) != PAR_ODD;
            FrameError  <= ~stop_s;
            DataReady   <= 1'b1;
            // An acknowledge coinciding with delivery consumes the old character.
            if (DataReady) Overrun <= ~ReadAck;
        end else if (ReadAck && DataReady) begin
            DataReady <= 1'b0;
            Overrun   <= 1'b0;
        end
    end

    assign Busy = (state != S_IDLE);

endmodule

// File: tb/tb_bit_receiver.sv
// Directed and randomized bench for bit_receiver (CLKS_PER_BIT=16, even parity).
`timescale 1ps/1ps
module tb_bit_receiver;

    localparam int CPB = 16;
    localparam int PAR = 0;
    localparam int TCLK = 10000;

    logic       clk = 1'b0;
    logic       Reset;
    logic       RxBit;
    logic       ReadAck;
    logic [6:0] Char;
    logic       RxParity, DataReady, ParityError, FrameError, Overrun, Busy;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [6:0] m_char;
    logic       m_par, m_pe, m_fe, m_ready, m_ovr;

    bit_receiver #(.CLKS_PER_BIT(CPB), .PARITY_ODD(PAR)) dut (
        .clk(clk), .Reset(Reset), .RxBit(RxBit), .ReadAck(ReadAck),
        .Char(Char), .RxParity(RxParity), .DataReady(DataReady),
        .ParityError(ParityError), .FrameError(FrameError),
        .Overrun(Overrun), .Busy(Busy)
    );

    always #(TCLK/2) clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic void model_reset();
        m_char = '0; m_par = 0; m_pe = 0; m_fe = 0; m_ready = 0; m_ovr = 0;
    endfunction

    // A completed frame as the consumer should see it.
    function automatic void model_deliver(input logic [6:0] d, input logic p, input logic s,
                                          input logic ack);
        int ones;
        ones   = $countones(d) + int'(p);
        m_char = d;
        m_par  = p;
        m_pe   = ((ones % 2) != PAR);
        m_fe   = (s == 1'b0);
        if (m_ready) m_ovr = !ack;
        m_ready = 1'b1;
    endfunction

    function automatic void model_ack();
        if (m_ready) begin
            m_ready = 0;
            m_ovr   = 0;
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".char"},   8'(Char),        8'(m_char));
        chk({tag, ".par"},    8'(RxParity),    8'(m_par));
        chk({tag, ".perr"},   8'(ParityError), 8'(m_pe));
        chk({tag, ".ferr"},   8'(FrameError),  8'(m_fe));
        chk({tag, ".ready"},  8'(DataReady),   8'(m_ready));
        chk({tag, ".ovr"},    8'(Overrun),     8'(m_ovr));
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Clock-locked transmitter; call after align(). Leaves the line at the stop level.
    task automatic send_sync(input logic [6:0] d, input logic p, input logic s);
        logic [9:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RxBit = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    // Free-running transmitter with its own bit period in ps.
    task automatic send_async(input logic [6:0] d, input logic p, input int per);
        logic [9:0] f;
        f = {1'b1, p, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RxBit = f[i];
            #(per);
        end
    endtask

    task automatic pulse_ack();
        @(posedge clk); #1 ReadAck = 1'b1;
        @(posedge clk); #1 ReadAck = 1'b0;
    endtask

    initial begin
        int n;
        logic [6:0] rd;
        logic rp;
        int per, gap;

        Reset = 1'b1; RxBit = 1'b1; ReadAck = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        chk("reset.busy", 8'(Busy), 8'd0);
        align();
        Reset = 1'b0;

        // 0x41 good parity, with latency measurement from the falling edge
        n = 0;
        align();
        fork
            send_sync(7'h41, 1'b0, 1'b1);
            begin
                while (DataReady !== 1'b1 && n < 400) begin
                    @(negedge clk);
                    n++;
                end
            end
        join
        RxBit = 1'b1;
        chk("latency_window", 8'((n - 1) >= 154 && (n - 1) <= 157), 8'd1);
        model_deliver(7'h41, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_all("f41");
        pulse_ack(); model_ack();
        @(negedge clk);
        check_all("f41_ack");

        // bad parity, then a good frame on top of it, then acknowledge
        align();
        send_sync(7'h41, 1'b1, 1'b1);
        RxBit = 1'b1;
        model_deliver(7'h41, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check_all("f41_bad_par");
        align();
        send_sync(7'h7F, 1'b1, 1'b1);
        RxBit = 1'b1;
        model_deliver(7'h7F, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check_all("f7f");
        pulse_ack(); model_ack();
        @(negedge clk);
        check_all("f7f_ack");

        // framing error with a held-low line
        align();
        send_sync(7'h55, 1'b0, 1'b0);
        repeat (40) @(posedge clk);
        model_deliver(7'h55, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_all("break");
        chk("break.busy_low", 8'(Busy), 8'd1);
        pulse_ack(); model_ack();
        @(negedge clk);
        chk("break.busy_still", 8'(Busy), 8'd1);
        align();
        RxBit = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("break.busy_release", 8'(Busy), 8'd0);
        repeat (200) @(posedge clk);
        @(negedge clk);
        check_all("break_no_second");

        // 4-clk glitch is a false start
        align();
        RxBit = 1'b0;
        repeat (4) @(posedge clk);
        #1 RxBit = 1'b1;
        @(negedge clk);
        chk("glitch.busy_hi", 8'(Busy), 8'd1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("glitch.busy_lo", 8'(Busy), 8'd0);
        chk("glitch.ready", 8'(DataReady), 8'd0);

        // back-to-back, no acknowledge -> overrun
        align();
        send_sync(7'h12, 1'b0, 1'b1);
        send_sync(7'h34, 1'b1, 1'b1);
        RxBit = 1'b1;
        model_deliver(7'h12, 1'b0, 1'b1, 1'b0);
        model_deliver(7'h34, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check_all("b2b");

        // acknowledge landing exactly on the delivery cycle
        align();
        fork
            send_sync(7'h56, 1'b0, 1'b1);
            begin
                repeat (155) @(posedge clk);
                #1 ReadAck = 1'b1;
                @(posedge clk);
                #1 ReadAck = 1'b0;
            end
        join
        RxBit = 1'b1;
        model_deliver(7'h56, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check_all("ack_on_deliver");
        pulse_ack(); model_ack();

        // random frames from an unsynchronized transmitter within +/-3% bit period
        for (int k = 0; k < 10; k++) begin
            rd  = 7'($urandom_range(0, 127));
            rp  = 1'($urandom_range(0, 1));
            per = $urandom_range(CPB * TCLK * 97 / 100, CPB * TCLK * 103 / 100);
            gap = $urandom_range(0, 3 * TCLK);
            #(gap);
            send_async(rd, rp, per);
            RxBit = 1'b1;
            repeat (20) @(posedge clk);
            model_deliver(rd, rp, 1'b1, 1'b0);
            @(negedge clk);
            check_all("rand");
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack(); model_ack();
                @(negedge clk);
                chk("rand.ack", 8'(DataReady), 8'd0);
            end
        end

        // reset in the middle of the data bits
        align();
        RxBit = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        Reset = 1'b1;
        RxBit = 1'b1;
        @(posedge clk);
        #1 Reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_all("mid_reset");
        chk("mid_reset.busy", 8'(Busy), 8'd0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check_all("mid_reset_quiet");
        align();
        send_sync(7'h2A, 1'b1, 1'b1);
        RxBit = 1'b1;
        model_deliver(7'h2A, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check_all("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
